// File: rtl/muldiv_pkg.sv
// Shared decode constants and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [1:0] ULAOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring-divide step.
// The accumulator is {acc_hi, acc_lo}; opnd is the multiplicand (multiply) or divisor (divide).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shifted = {acc_hi_i, acc_lo_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};
    if (div_i) begin
      // diff[WIDTH] set means the trial subtraction went negative: restore
      if (!diff[WIDTH]) begin
        acc_hi_o = diff[WIDTH-1:0];
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_o = shifted[WIDTH-1:0];
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_o = sum[WIDTH:1];
      acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers for a multicycle MIPS datapath.
// Define MUL_DIV_SIGNED_EN to make MULT/DIV signed; otherwise they behave as MULTU/DIVU.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ula_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dz_q;

  logic             is_mul, is_div, accept;
  logic [WIDTH-1:0] a_lat_d, b_lat_d;
  logic [WIDTH-1:0] step_hi_d, step_lo_d;
  logic [WIDTH-1:0] res_hi_d, res_lo_d;

`ifdef MUL_DIV_SIGNED_EN
  logic neg_lo_q, neg_hi_q;
  logic neg_lo_d, neg_hi_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction
`endif

  always_comb begin
    is_mul = (funct == FN_MULT) || (funct == FN_MULTU);
    is_div = (funct == FN_DIV) || (funct == FN_DIVU);
    accept = start && (ula_op == ULAOP_RTYPE) && (is_mul || is_div);
    a_lat_d = a;
    b_lat_d = b;
`ifdef MUL_DIV_SIGNED_EN
    neg_lo_d = 1'b0;
    neg_hi_d = 1'b0;
    if ((funct == FN_MULT) || (funct == FN_DIV)) begin
      a_lat_d  = mag(a);
      b_lat_d  = mag(b);
      neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
      neg_hi_d = a[WIDTH-1];
    end
`endif
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i    (state_q == DIV),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opnd_i   (opnd_q),
    .acc_hi_o (step_hi_d),
    .acc_lo_o (step_lo_d)
  );

  // Sign fix-up of the final iteration's result, applied only as it enters HI/LO
  always_comb begin
    res_hi_d = step_hi_d;
    res_lo_d = step_lo_d;
`ifdef MUL_DIV_SIGNED_EN
    if (state_q == MUL) begin
      if (neg_lo_q) {res_hi_d, res_lo_d} = ~{step_hi_d, step_lo_d} + 1'b1;
    end else begin
      if (neg_lo_q) res_lo_d = ~step_lo_d + 1'b1;
      if (neg_hi_q) res_hi_d = ~step_hi_d + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          dz_q   <= 1'b0;
          if (accept) begin
            if (is_div && (b == '0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else begin
              state_q  <= is_mul ? MUL : DIV;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              acc_hi_q <= '0;
              acc_lo_q <= is_mul ? b_lat_d : a_lat_d;
              opnd_q   <= is_mul ? a_lat_d : b_lat_d;
`ifdef MUL_DIV_SIGNED_EN
              neg_lo_q <= neg_lo_d;
              neg_hi_q <= neg_hi_d;
`endif
            end
          end
        end
        MUL, DIV: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          dz_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start32, busy32, done32, dz32;
  logic [1:0]  ula32;
  logic [5:0]  funct32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        start8, busy8, done8, dz8;
  logic [1:0]  ula8;
  logic [5:0]  funct8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_hi32 = '0, exp_lo32 = '0;
  logic        exp_dz32;
  logic [7:0]  exp_hi8 = '0, exp_lo8 = '0;
  logic        exp_dz8;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .ula_op(ula32), .funct(funct32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .ula_op(ula8), .funct(funct8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  function automatic logic is_signed_fn(input logic [5:0] f);
    logic s;
    s = 1'b0;
`ifdef MUL_DIV_SIGNED_EN
    s = (f == 6'h18) || (f == 6'h1A);
`endif
    return s;
  endfunction

  function automatic void model32(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint p, q, r;
    exp_dz32 = 1'b0;
    if (f == 6'h18 || f == 6'h19) begin
      if (is_signed_fn(f)) p = longint'($signed(x)) * longint'($signed(y));
      else                 p = longint'(x) * longint'(y);
      exp_hi32 = p[63:32];
      exp_lo32 = p[31:0];
    end else if (y == 0) begin
      exp_dz32 = 1'b1;
    end else begin
      if (is_signed_fn(f)) begin
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
      end else begin
        q = longint'(x) / longint'(y);
        r = longint'(x) % longint'(y);
      end
      exp_hi32 = r[31:0];
      exp_lo32 = q[31:0];
    end
  endfunction

  function automatic void model8(input logic [5:0] f, input logic [7:0] x, input logic [7:0] y);
    int p, q, r;
    exp_dz8 = 1'b0;
    if (f == 6'h18 || f == 6'h19) begin
      if (is_signed_fn(f)) p = int'($signed(x)) * int'($signed(y));
      else                 p = int'(x) * int'(y);
      exp_hi8 = p[15:8];
      exp_lo8 = p[7:0];
    end else if (y == 0) begin
      exp_dz8 = 1'b1;
    end else begin
      if (is_signed_fn(f)) begin
        q = int'($signed(x)) / int'($signed(y));
        r = int'($signed(x)) % int'($signed(y));
      end else begin
        q = int'(x) / int'(y);
        r = int'(x) % int'(y);
      end
      exp_hi8 = r[7:0];
      exp_lo8 = q[7:0];
    end
  endfunction

  // Issues one op, scrambles a/b while iterating, measures latency, busy cycles and pulse width
  task automatic run32(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                       output int cyc, output int bcnt, output logic dz, output logic single);
    @(negedge clk);
    start32 = 1'b1; ula32 = 2'b10; funct32 = f; a32 = x; b32 = y;
    @(posedge clk); #1 start32 = 1'b0;
    cyc = 0; bcnt = 0; dz = 1'b0; single = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom;
      cyc++;
      if (busy32) bcnt++;
      if (done32) begin dz = dz32; break; end
    end
    @(negedge clk);
    single = !done32 && !dz32;
  endtask

  task automatic run8(input logic [5:0] f, input logic [7:0] x, input logic [7:0] y,
                      output int cyc, output logic dz);
    @(negedge clk);
    start8 = 1'b1; ula8 = 2'b10; funct8 = f; a8 = x; b8 = y;
    @(posedge clk); #1 start8 = 1'b0;
    cyc = 0; dz = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cyc++;
      if (done8) begin dz = dz8; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy32, done32, dz32, hi32, lo32} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset32: busy=%b done=%b dz=%b hi=%h lo=%h, required all zero", busy32, done32, dz32, hi32, lo32);
    end
    n_checks++;
    if ({busy8, done8, dz8, hi8, lo8} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b dz=%b hi=%h lo=%h, required all zero", busy8, done8, dz8, hi8, lo8);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int cyc, bcnt; logic dz, single;
    run32(6'h19, 32'hFFFF_FFFF, 32'h2, cyc, bcnt, dz, single);
    n_checks++;
    if (cyc !== 33 || bcnt !== 32) begin
      n_fail++; $display("FAIL multu_timing: latency=%0d busy=%0d, required 33 and 32", cyc, bcnt);
    end
    n_checks++;
    if (hi32 !== 32'h1 || lo32 !== 32'hFFFF_FFFE || dz) begin
      n_fail++; $display("FAIL multu_result: hi=%h lo=%h dz=%b, required 1 fffffffe 0", hi32, lo32, dz);
    end
    n_checks++;
    if (!single) begin n_fail++; $display("FAIL multu_pulse: done still high after one cycle, required one-cycle pulse"); end
  endtask

  task automatic test_divu;
    int cyc, bcnt; logic dz, single;
    run32(6'h1B, 32'd100, 32'd7, cyc, bcnt, dz, single);
    n_checks++;
    if (lo32 !== 32'd14 || hi32 !== 32'd2 || dz !== 1'b0 || cyc !== 33) begin
      n_fail++; $display("FAIL divu_100_7: lo=%0d hi=%0d dz=%b lat=%0d, required 14 2 0 33", lo32, hi32, dz, cyc);
    end
    run32(6'h1B, 32'd5, 32'd0, cyc, bcnt, dz, single);
    n_checks++;
    if (cyc !== 1 || dz !== 1'b1 || bcnt !== 0 || lo32 !== 32'd14 || hi32 !== 32'd2) begin
      n_fail++; $display("FAIL divu_by_zero: lat=%0d dz=%b busy=%0d lo=%0d hi=%0d, required 1 1 0 14 2", cyc, dz, bcnt, lo32, hi32);
    end
    n_checks++;
    if (!single) begin n_fail++; $display("FAIL div_zero_clear: done/div_zero high after exit, required cleared"); end
  endtask

  task automatic test_signedness;
    int cyc, bcnt; logic dz, single;
    logic [31:0] rh, rl;
`ifdef MUL_DIV_SIGNED_EN
    run32(6'h1A, -32'sd7, 32'sd2, cyc, bcnt, dz, single);
    n_checks++;
    if (lo32 !== 32'hFFFF_FFFD || hi32 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sdiv_m7_2: lo=%h hi=%h, required fffffffd ffffffff", lo32, hi32);
    end
    run32(6'h18, -32'sd3, 32'sd4, cyc, bcnt, dz, single);
    n_checks++;
    if (hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFF4) begin
      n_fail++; $display("FAIL smul_m3_4: hi=%h lo=%h, required ffffffff fffffff4", hi32, lo32);
    end
    run32(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt, dz, single);
    n_checks++;
    if (lo32 !== 32'h8000_0000 || hi32 !== 32'h0) begin
      n_fail++; $display("FAIL sdiv_minneg: lo=%h hi=%h, required 80000000 0", lo32, hi32);
    end
`else
    run32(6'h18, 32'hFFFF_FFFF, 32'h2, cyc, bcnt, dz, single);
    n_checks++;
    if (hi32 !== 32'h1 || lo32 !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mult_unsigned: hi=%h lo=%h, required 1 fffffffe", hi32, lo32);
    end
    run32(6'h1A, 32'hFFFF_FFF9, 32'h2, cyc, bcnt, dz, single);
    n_checks++;
    if (lo32 !== 32'h7FFF_FFFC || hi32 !== 32'h1) begin
      n_fail++; $display("FAIL div_unsigned: lo=%h hi=%h, required 7ffffffc 1", lo32, hi32);
    end
`endif
    model32(6'h18, 32'hFFFF_FFF0, 32'h0000_0123);
    rh = exp_hi32; rl = exp_lo32;
    run32(6'h18, 32'hFFFF_FFF0, 32'h0000_0123, cyc, bcnt, dz, single);
    n_checks++;
    if (hi32 !== rh || lo32 !== rl) begin
      n_fail++; $display("FAIL mult_mixed: hi=%h lo=%h, required %h %h", hi32, lo32, rh, rl);
    end
  endtask

  task automatic test_ignored;
    int bad, cyc;
    logic [31:0] h0, l0;
    h0 = hi32; l0 = lo32; bad = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start32 = 1'b1;
      ula32   = (k == 0) ? 2'b10 : 2'b00;
      funct32 = (k == 0) ? 6'h20 : 6'h19;
      a32 = 32'd9; b32 = 32'd9;
      @(negedge clk); start32 = 1'b0;
      repeat (5) begin
        if (busy32 || done32) bad++;
        @(negedge clk);
      end
    end
    n_checks++;
    if (bad !== 0 || hi32 !== h0 || lo32 !== l0) begin
      n_fail++; $display("FAIL ignored_op: activity=%0d hi=%h lo=%h, required 0 %h %h", bad, hi32, lo32, h0, l0);
    end
    // Second start arrives mid-iteration and must be dropped
    @(negedge clk);
    start32 = 1'b1; ula32 = 2'b10; funct32 = 6'h19; a32 = 32'd3; b32 = 32'd5;
    @(posedge clk); #1 start32 = 1'b0;
    cyc = 0; bad = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      start32 = (cyc == 5);
      funct32 = 6'h1B; a32 = 32'd100; b32 = 32'd7;
      if (done32) break;
    end
    start32 = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done32 || busy32) bad++;
    end
    n_checks++;
    if (cyc !== 33 || lo32 !== 32'd15 || hi32 !== 32'd0 || bad !== 0) begin
      n_fail++; $display("FAIL start_while_busy: lat=%0d lo=%0d hi=%0d extra=%0d, required 33 15 0 0", cyc, lo32, hi32, bad);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bcnt; logic dz, single;
    @(negedge clk);
    start32 = 1'b1; ula32 = 2'b10; funct32 = 6'h18; a32 = 32'd123; b32 = 32'd456;
    @(posedge clk); #1 start32 = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy32 !== 1'b1) begin n_fail++; $display("FAIL mid_busy: busy=%b, required 1", busy32); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy32, done32, dz32, hi32, lo32} !== 67'd0) begin
      n_fail++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required all zero", busy32, done32, hi32, lo32);
    end
    @(negedge clk); reset = 1'b0;
    run32(6'h19, 32'd6, 32'd7, cyc, bcnt, dz, single);
    n_checks++;
    if (lo32 !== 32'd42 || hi32 !== 32'd0 || cyc !== 33) begin
      n_fail++; $display("FAIL after_reset_multu: lo=%0d hi=%0d lat=%0d, required 42 0 33", lo32, hi32, cyc);
    end
    exp_hi32 = 32'd0; exp_lo32 = 32'd42;
    exp_hi8  = 8'd0;  exp_lo8  = 8'd0;
  endtask

  task automatic test_random8;
    int cyc; logic dz; logic [5:0] f; logic [7:0] x, y;
    for (int i = 0; i < 60; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      x = 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (i == 0) begin f = 6'h1A; x = 8'h80; y = 8'hFF; end
      model8(f, x, y);
      run8(f, x, y, cyc, dz);
      n_checks++;
      if (hi8 !== exp_hi8 || lo8 !== exp_lo8 || dz !== exp_dz8 || cyc !== (exp_dz8 ? 1 : 9)) begin
        n_fail++;
        $display("FAIL rand8 f=%h a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d, required %h %h %b %0d",
                 f, x, y, hi8, lo8, dz, cyc, exp_hi8, exp_lo8, exp_dz8, exp_dz8 ? 1 : 9);
      end
    end
  endtask

  task automatic test_random32;
    int cyc, bcnt; logic dz, single; logic [5:0] f; logic [31:0] x, y;
    for (int i = 0; i < 16; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : (i[0] ? $urandom : 32'($urandom_range(1, 1000)));
      model32(f, x, y);
      run32(f, x, y, cyc, bcnt, dz, single);
      n_checks++;
      if (hi32 !== exp_hi32 || lo32 !== exp_lo32 || dz !== exp_dz32 || cyc !== (exp_dz32 ? 1 : 33)) begin
        n_fail++;
        $display("FAIL rand32 f=%h a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d, required %h %h %b %0d",
                 f, x, y, hi32, lo32, dz, cyc, exp_hi32, exp_lo32, exp_dz32, exp_dz32 ? 1 : 33);
      end
    end
  endtask

  initial begin
    start32 = 1'b0; ula32 = 2'b00; funct32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; ula8  = 2'b00; funct8  = '0; a8  = '0; b8  = '0;
    test_reset;
    test_multu;
    test_divu;
    test_signedness;
    test_ignored;
    test_reset_mid;
    test_random8;
    test_random32;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
